// File: rtl/id_forward_scoreboard.sv
// rtl/id_forward_scoreboard.sv - ID-stage operand forwarding with in-flight destination-tag scoreboard
module id_forward_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NUM_RS = 2,
    parameter int STAGES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic                     id_wen,
    input  logic [4:0]               id_rd,
    input  logic [5*NUM_RS-1:0]      id_rs,
    input  logic [XLEN*NUM_RS-1:0]   rf_data,
    input  logic [XLEN*STAGES-1:0]   stage_data,
    input  logic [STAGES-1:0]        stage_done,
    input  logic                     advance,
    input  logic                     flush,
    output logic [XLEN*NUM_RS-1:0]   rs_data,
    output logic                     stall,
    output logic [2*NUM_RS-1:0]      fwd_src,
    output logic [31:0]              stall_cnt
);

    logic [STAGES-1:0]      vld_q, vld_d;
    logic [STAGES-1:0]      rdy_q, rdy_d;
    logic [STAGES-1:0][4:0] tag_q, tag_d;
    logic [31:0]            stall_cnt_q, stall_cnt_d;

    logic [STAGES-1:0]      eff_rdy;
    logic [STAGES-1:0]      live;
    logic [NUM_RS-1:0]      port_hit;
    logic [NUM_RS-1:0]      port_rdy;

    // A live entry never carries tag x0, so a source of x0 can never match.
    always_comb begin
        eff_rdy = rdy_q | stage_done;
        live    = '0;
        for (int s = 0; s < STAGES; s++) begin
            live[s] = vld_q[s] & (tag_q[s] != 5'd0);
        end
    end

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        rs_data  = rf_data;
        fwd_src  = '0;
        port_hit = '0;
        port_rdy = '0;
        for (int p = 0; p < NUM_RS; p++) begin
            for (int s = STAGES - 1; s >= 0; s--) begin
                if (live[s] && (tag_q[s] == id_rs[5*p +: 5])) begin
                    port_hit[p]              = 1'b1;
                    port_rdy[p]              = eff_rdy[s];
                    rs_data[XLEN*p +: XLEN]  = stage_data[XLEN*s +: XLEN];
                end
            end
            if (port_hit[p]) begin
                fwd_src[2*p +: 2] = port_rdy[p] ? 2'd1 : 2'd2;
            end
        end
    end

    assign stall     = id_valid & (|(port_hit & ~port_rdy));
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        rdy_d = eff_rdy;
        if (advance) begin
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                tag_d[s] = tag_q[s-1];
                rdy_d[s] = eff_rdy[s-1];
            end
            // A stalled ID enters EX as a bubble.
            vld_d[0] = id_valid & id_wen & ~stall & ~flush;
            tag_d[0] = id_rd;
            rdy_d[0] = 1'b0;
        end else if (flush) begin
            vld_d[0] = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            rdy_q       <= '0;
            tag_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            rdy_q       <= rdy_d;
            tag_q       <= tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_forward_scoreboard.sv
// tb/tb_id_forward_scoreboard.sv - randomized and directed bench for id_forward_scoreboard
module tb_id_forward_scoreboard;

    localparam int XLEN   = 32;
    localparam int NUM_RS = 2;
    localparam int STAGES = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   id_valid;
    logic                   id_wen;
    logic [4:0]             id_rd;
    logic [5*NUM_RS-1:0]    id_rs;
    logic [XLEN*NUM_RS-1:0] rf_data;
    logic [XLEN*STAGES-1:0] stage_data;
    logic [STAGES-1:0]      stage_done;
    logic                   advance;
    logic                   flush;
    logic [XLEN*NUM_RS-1:0] rs_data;
    logic                   stall;
    logic [2*NUM_RS-1:0]    fwd_src;
    logic [31:0]            stall_cnt;

    always #5 clk = ~clk;

    id_forward_scoreboard #(.XLEN(XLEN), .NUM_RS(NUM_RS), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wen(id_wen), .id_rd(id_rd),
        .id_rs(id_rs), .rf_data(rf_data), .stage_data(stage_data), .stage_done(stage_done),
        .advance(advance), .flush(flush), .rs_data(rs_data), .stall(stall),
        .fwd_src(fwd_src), .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit       vld;
        bit [4:0] tag;
        bit       rdy;
    } entry_t;

    entry_t    pipe[$];   // pipe[0] = EX, pipe[STAGES-1] = WB
    bit [31:0] m_cnt;
    bit        exp_stall;
    int        vectors     = 0;
    int        miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        entry_t e;
        e.vld = 1'b0; e.tag = 5'd0; e.rdy = 1'b0;
        pipe.delete();
        for (int i = 0; i < STAGES; i++) pipe.push_back(e);
        m_cnt = 32'd0;
    endtask

    // Compare all outputs against the model on the falling edge.
    task automatic settle();
        @(negedge clk);
        exp_stall = 1'b0;
        for (int p = 0; p < NUM_RS; p++) begin
            int       hit;
            bit [4:0] src;
            hit = -1;
            src = id_rs[5*p +: 5];
            for (int s = 0; s < STAGES; s++) begin
                if (hit < 0 && pipe[s].vld && pipe[s].tag != 5'd0 && pipe[s].tag == src) hit = s;
            end
            if (hit < 0) begin
                check($sformatf("fwd_src[%0d]", p), fwd_src[2*p +: 2], 64'd0);
                check($sformatf("rs_data[%0d]", p), rs_data[XLEN*p +: XLEN], rf_data[XLEN*p +: XLEN]);
            end else if (pipe[hit].rdy || stage_done[hit]) begin
                check($sformatf("fwd_src[%0d]", p), fwd_src[2*p +: 2], 64'd1);
                check($sformatf("rs_data[%0d]", p), rs_data[XLEN*p +: XLEN], stage_data[XLEN*hit +: XLEN]);
            end else begin
                check($sformatf("fwd_src[%0d]", p), fwd_src[2*p +: 2], 64'd2);
                if (id_valid) exp_stall = 1'b1;
            end
        end
        check("stall", stall, exp_stall);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic commit();
        entry_t n;
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else begin
            for (int s = 0; s < STAGES; s++) pipe[s].rdy = pipe[s].rdy | stage_done[s];
            if (advance) begin
                n.vld = id_valid && id_wen && !exp_stall && !flush;
                n.tag = id_rd;
                n.rdy = 1'b0;
                pipe.push_front(n);
                void'(pipe.pop_back());
            end else if (flush) begin
                pipe[0].vld = 1'b0;
            end
            if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic idle();
        rst        = 1'b0;
        id_valid   = 1'b0;
        id_wen     = 1'b0;
        id_rd      = 5'd0;
        id_rs      = '0;
        stage_done = '0;
        advance    = 1'b1;
        flush      = 1'b0;
        for (int p = 0; p < NUM_RS; p++) rf_data[XLEN*p +: XLEN] = $urandom;
        for (int s = 0; s < STAGES; s++) stage_data[XLEN*s +: XLEN] = $urandom;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        id_valid = 1'b1;
        id_wen   = 1'b1;
        id_rd    = rd;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        commit();
    endtask

    initial begin
        clear_model();
        do_reset();

        // Post-reset outputs
        idle();
        settle();
        check("rst_stall", stall, 0);
        check("rst_fwd_src", fwd_src, 0);
        check("rst_rs_data", rs_data, rf_data);
        check("rst_stall_cnt", stall_cnt, 0);
        commit();

        // Back-to-back ALU RAW
        do_reset();
        issue(5'd5); settle(); commit();
        idle(); id_valid = 1'b1; id_rs[4:0] = 5'd5;
        stage_done[0] = 1'b1; stage_data[31:0] = 32'h11;
        settle();
        check("raw_data", rs_data[31:0], 32'h11);
        check("raw_src", fwd_src[1:0], 1);
        check("raw_stall", stall, 0);
        commit();

        // Load-use
        do_reset();
        issue(5'd7); settle(); commit();
        issue(5'd8); id_rs[9:5] = 5'd7;
        settle();
        check("lu_stall", stall, 1);
        check("lu_src", fwd_src[3:2], 2);
        commit();
        issue(5'd8); id_rs[9:5] = 5'd7;
        stage_done[1] = 1'b1; stage_data[63:32] = 32'hABCD;
        settle();
        check("lu_stall_clear", stall, 0);
        check("lu_data", rs_data[63:32], 32'hABCD);
        check("lu_cnt", stall_cnt, 1);
        commit();

        // Youngest wins: x3 in EX (not ready) and WB (ready)
        do_reset();
        issue(5'd3); settle(); commit();
        idle(); stage_done[0] = 1'b1; settle(); commit();
        issue(5'd3); settle(); commit();
        idle(); id_valid = 1'b1; id_rs[4:0] = 5'd3; advance = 1'b0;
        stage_data[31:0] = 32'h2; stage_data[95:64] = 32'h1;
        settle();
        check("yw_stall", stall, 1);
        check("yw_src", fwd_src[1:0], 2);
        commit();
        idle(); id_valid = 1'b1; id_rs[4:0] = 5'd3; advance = 1'b0;
        stage_data[31:0] = 32'h2; stage_data[95:64] = 32'h1; stage_done[0] = 1'b1;
        settle();
        check("yw_data", rs_data[31:0], 32'h2);
        check("yw_src_rdy", fwd_src[1:0], 1);
        check("yw_stall_clear", stall, 0);
        commit();

        // x0 guard
        do_reset();
        issue(5'd0); settle(); commit();
        idle(); id_valid = 1'b1; id_rs[4:0] = 5'd0; rf_data[31:0] = 32'h0;
        settle();
        check("x0_data", rs_data[31:0], 0);
        check("x0_src", fwd_src[1:0], 0);
        check("x0_stall", stall, 0);
        commit();

        // Held pipeline with sticky ready, plus counter saturation
        do_reset();
        issue(5'd9); settle(); commit();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            idle(); id_valid = 1'b1; id_rs[4:0] = 5'd9; advance = 1'b0;
            settle();
            check("hold_stall", stall, 1);
            commit();
        end
        idle(); id_valid = 1'b1; id_rs[4:0] = 5'd9; advance = 1'b0;
        stage_done[0] = 1'b1; stage_data[31:0] = 32'h99;
        settle();
        check("hold_src", fwd_src[1:0], 1);
        check("hold_stall_clear", stall, 0);
        check("sat_cnt", stall_cnt, 32'hFFFF_FFFF);
        commit();
        idle(); id_valid = 1'b1; id_rs[4:0] = 5'd9; advance = 1'b0;
        stage_data[31:0] = 32'h99;
        settle();
        check("hold_sticky_src", fwd_src[1:0], 1);
        check("hold_sticky_data", rs_data[31:0], 32'h99);
        commit();

        // Flush squashes only the incoming instruction
        do_reset();
        issue(5'd6); settle(); commit();
        issue(5'd4); flush = 1'b1; settle(); commit();
        idle(); id_valid = 1'b1; id_rs[4:0] = 5'd4; id_rs[9:5] = 5'd6;
        stage_done[1] = 1'b1; stage_data[63:32] = 32'h66;
        settle();
        check("fl_src", fwd_src[1:0], 0);
        check("fl_data", rs_data[31:0], rf_data[31:0]);
        check("fl_old_src", fwd_src[3:2], 1);
        check("fl_old_data", rs_data[63:32], 32'h66);
        commit();

        // Reset mid-stall
        do_reset();
        issue(5'd7); settle(); commit();
        idle(); id_valid = 1'b1; id_rs = {5'd7, 5'd7};
        settle();
        check("rm_stall", stall, 1);
        commit();
        idle(); id_valid = 1'b1; id_rs = {5'd7, 5'd7}; rst = 1'b1;
        settle(); commit();
        idle(); id_valid = 1'b1; id_rs = {5'd7, 5'd7};
        settle();
        check("rm_stall_clear", stall, 0);
        check("rm_src", fwd_src, 0);
        check("rm_cnt", stall_cnt, 0);
        commit();

        // Randomized traffic over a small register window to force frequent hits
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst      = ($urandom_range(0, 199) == 0);
            id_valid = $urandom_range(0, 3) != 0;
            id_wen   = $urandom_range(0, 3) != 0;
            id_rd    = 5'($urandom_range(0, 7));
            for (int p = 0; p < NUM_RS; p++) id_rs[5*p +: 5] = 5'($urandom_range(0, 7));
            for (int s = 0; s < STAGES; s++) stage_done[s] = $urandom_range(0, 2) == 0;
            advance  = $urandom_range(0, 3) != 0;
            flush    = $urandom_range(0, 9) == 0;
            settle();
            commit();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
